// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: frames one command with slave select, a setup/hold gap
// and an SCLK count taken from the clock generator's neg_edge pulses.
module spi_xfer_ctrl #(
  parameter int LEN_W = 7,
  parameter int DIV_W = 16,
  parameter int SS_NB = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] char_len,
  input  logic [DIV_W-1:0] div_in,
  input  logic [SS_NB-1:0] ss_sel,
  input  logic             ass,
  input  logic [GAP_W-1:0] gap,
  input  logic             pos_edge,
  input  logic             neg_edge,
  output logic             go,
  output logic             enable,
  output logic             last_clk,
  output logic [DIV_W-1:0] divider,
  output logic [LEN_W:0]   bit_cnt,
  output logic [SS_NB-1:0] ss_pad_o,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

  localparam logic [LEN_W:0]   FULL_LEN = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]   CNT_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]   CNT_TWO  = (LEN_W+1)'(2);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t           state;
  logic [SS_NB-1:0] ss_lat;
  logic [GAP_W-1:0] gap_lat;
  logic [GAP_W-1:0] gap_cnt;
  logic [SS_NB-1:0] ss_idle;
  logic [SS_NB-1:0] ss_act;

  // With manual select the pads follow ss_sel in every state.
  assign ss_idle = ass ? '1 : ~ss_sel;
  assign ss_act  = ass ? ~ss_lat : ~ss_sel;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      go       <= 1'b0;
      enable   <= 1'b0;
      last_clk <= 1'b0;
      divider  <= '1;
      bit_cnt  <= '0;
      ss_pad_o <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      ss_lat   <= '0;
      gap_lat  <= '0;
      gap_cnt  <= '0;
    end else begin
      go      <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      if (state != IDLE && abort) begin
        state    <= IDLE;
        enable   <= 1'b0;
        last_clk <= 1'b0;
        bit_cnt  <= '0;
        busy     <= 1'b0;
        aborted  <= 1'b1;
        ss_pad_o <= ss_idle;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state    <= SETUP;
              busy     <= 1'b1;
              bit_cnt  <= (char_len == '0) ? FULL_LEN : {1'b0, char_len};
              divider  <= div_in;
              ss_lat   <= ss_sel;
              gap_lat  <= gap;
              gap_cnt  <= gap;
              ss_pad_o <= ~ss_sel;
            end else begin
              ss_pad_o <= ss_idle;
            end
          end
          SETUP: begin
            ss_pad_o <= ss_act;
            if (gap_cnt == '0) begin
              state    <= RUN;
              go       <= 1'b1;
              enable   <= 1'b1;
              last_clk <= (bit_cnt == CNT_ONE);
            end else begin
              gap_cnt <= gap_cnt - GAP_ONE;
            end
          end
          RUN: begin
            ss_pad_o <= ss_act;
            if (neg_edge) begin
              if (bit_cnt == CNT_ONE) begin
                state    <= HOLD;
                bit_cnt  <= '0;
                enable   <= 1'b0;
                last_clk <= 1'b0;
                gap_cnt  <= gap_lat;
              end else begin
                bit_cnt  <= bit_cnt - CNT_ONE;
                last_clk <= (bit_cnt == CNT_TWO);
              end
            end
          end
          HOLD: begin
            if (gap_cnt == '0) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              ss_pad_o <= ss_idle;
            end else begin
              gap_cnt  <= gap_cnt - GAP_ONE;
              ss_pad_o <= ss_act;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // SCLK rises and falls are separate events; both in one cycle means a broken generator.
  assert property (@(posedge clk_in) disable iff (!rst_n) !(pos_edge && neg_edge));

endmodule
